// File: rtl/sram_lane_rmw_ctrl.sv
// sram_lane_rmw_ctrl: lane-split SRAM front end with byte-enable writes done as read-modify-write
module sram_lane_rmw_ctrl #(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 8,
    parameter int DEPTH     = 4096,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter bit LANE0_MSB = 1'b1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        req_i,
    output logic                        gnt_o,
    input  logic                        we_i,
    input  logic [NUM_LANES-1:0]        be_i,
    input  logic [ADDR_W-1:0]           a_i,
    input  logic [NUM_LANES*LANE_W-1:0] d_i,
    output logic                        rvalid_o,
    output logic [NUM_LANES*LANE_W-1:0] q_o,
    output logic                        mem_csn_o,
    output logic                        mem_wen_o,
    output logic [ADDR_W-1:0]           mem_a_o,
    output logic [NUM_LANES*LANE_W-1:0] mem_d_o,
    input  logic [NUM_LANES*LANE_W-1:0] mem_q_i
);
    localparam int DW = NUM_LANES * LANE_W;

    typedef enum logic {IDLE, MERGE} state_t;

    state_t                state_q, state_d;
    logic                  rvalid_q;
    logic [ADDR_W-1:0]     a_q, a_last_q;
    logic [DW-1:0]         d_q, d_last_q, merged;
    logic [NUM_LANES-1:0]  be_q;
    logic                  accept, rd, full, part, merge;

    // Lane reversal is its own inverse, so one function serves both directions.
    function automatic logic [DW-1:0] lane_map(input logic [DW-1:0] w);
        lane_map = '0;
        for (int k = 0; k < NUM_LANES; k++)
            lane_map[k*LANE_W +: LANE_W] = LANE0_MSB ? w[(NUM_LANES-1-k)*LANE_W +: LANE_W] : w[k*LANE_W +: LANE_W];
    endfunction

    assign gnt_o  = (state_q == IDLE) && !rst_i;
    assign accept = req_i && gnt_o;
    assign rd     = accept && !we_i;
    assign full   = accept && we_i && (&be_i);
    assign part   = accept && we_i && (|be_i) && !(&be_i);
    assign merge  = (state_q == MERGE) && !rst_i;

    // Merge held write lanes over the word read back from the macro (user lane order).
    always_comb begin
        merged = lane_map(mem_q_i);
        for (int k = 0; k < NUM_LANES; k++)
            if (be_q[k]) merged[k*LANE_W +: LANE_W] = d_q[k*LANE_W +: LANE_W];
    end

    // Macro drive; address/data hold their last value when idle to avoid toggling.
    always_comb begin
        mem_csn_o = !(rd || full || part || merge);
        mem_wen_o = !(full || merge);
        mem_a_o   = merge ? a_q : (rd || full || part) ? a_i : a_last_q;
        mem_d_o   = merge ? lane_map(merged) : full ? lane_map(d_i) : d_last_q;
        state_d   = part ? MERGE : IDLE;
    end

    assign rvalid_o = rvalid_q;
    assign q_o      = rvalid_q ? lane_map(mem_q_i) : '0;

    // FSM, read-valid pipeline and held partial-write operands.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rvalid_q <= 1'b0;
            a_q      <= '0;
            d_q      <= '0;
            be_q     <= '0;
            a_last_q <= '0;
            d_last_q <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= rd;
            a_last_q <= mem_a_o;
            d_last_q <= mem_d_o;
            if (part) begin
                a_q  <= a_i;
                d_q  <= d_i;
                be_q <= be_i;
            end
        end
    end
endmodule
